// File: rtl/clock_sequencer.sv
// clock_sequencer
//
// Brings up and supervises the board clock chain: 33 MHz in, then PLL
// (100 MHz), then DCM (48 MHz). It releases the PLL reset, waits for
// PLL lock, pulses the DCM reset and waits for DCM lock. Each lock wait
// has a timeout, and the number of consecutive timeouts is bounded.
// The downstream system reset is held until the 48 MHz clock has settled.
// Once running, loss of PLL lock restarts from the PLL stage. Loss of DCM
// lock, or a stopped CLKFX, restarts from the DCM stage.
//
// Ports
//   clk_33            free-running 33 MHz clock, the only clock
//   rst_n             synchronous active-low reset
//   restart           one-cycle request to re-run bring-up from scratch
//   pll_locked        PLL LOCKED (asynchronous)
//   dcm_locked        DCM LOCKED (asynchronous)
//   dcm_clkfx_stopped DCM STATUS[2] (asynchronous)
//   pll_rst           PLL reset, active high
//   dcm_rst           DCM reset, active high
//   sys_rst           downstream reset, active high
//   clk_ready         48 MHz clock valid and settled
//   fail              retries exhausted
//   retries           consecutive lock timeouts
//   state             current FSM state, for debug
module clock_sequencer #(
    parameter int PLL_RST_CYCLES = 4,
    parameter int DCM_RST_CYCLES = 4,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int SETTLE_CYCLES  = 16,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       clk_33,
    input  logic       rst_n,
    input  logic       restart,
    input  logic       pll_locked,
    input  logic       dcm_locked,
    input  logic       dcm_clkfx_stopped,
    output logic       pll_rst,
    output logic       dcm_rst,
    output logic       sys_rst,
    output logic       clk_ready,
    output logic       fail,
    output logic [2:0] retries,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_RST_PLL  = 3'd0,
        S_WAIT_PLL = 3'd1,
        S_RST_DCM  = 3'd2,
        S_WAIT_DCM = 3'd3,
        S_SETTLE   = 3'd4,
        S_RUN      = 3'd5,
        S_FAIL     = 3'd6
    } state_t;

    localparam logic [19:0] T_PLL_RST = 20'(PLL_RST_CYCLES - 1);
    localparam logic [19:0] T_DCM_RST = 20'(DCM_RST_CYCLES - 1);
    localparam logic [19:0] T_LOCK    = 20'(LOCK_TIMEOUT - 1);
    localparam logic [19:0] T_SETTLE  = 20'(SETTLE_CYCLES - 1);
    localparam logic [2:0]  R_MAX     = 3'(MAX_RETRIES);

    // Two-flop synchronizers. Bit order: {clkfx_stopped, dcm_locked, pll_locked}.
    logic [2:0] meta_reg, sync_reg;
    logic       pll_s, dcm_s, stop_s;

    always_ff @(posedge clk_33) begin
        if (!rst_n) begin
            meta_reg <= 3'b000;
            sync_reg <= 3'b000;
        end else begin
            meta_reg <= {dcm_clkfx_stopped, dcm_locked, pll_locked};
            sync_reg <= meta_reg;
        end
    end

    assign pll_s  = sync_reg[0];
    assign dcm_s  = sync_reg[1];
    assign stop_s = sync_reg[2];

    state_t      state_reg, state_next;
    logic [19:0] timer_reg, timer_next;
    logic [2:0]  retries_reg, retries_next, retries_inc;
    logic        pll_rst_next, dcm_rst_next, sys_rst_next, clk_ready_next, fail_next;

    assign retries_inc = retries_reg + 3'd1;

    always_comb begin
        state_next   = state_reg;
        retries_next = retries_reg;

        case (state_reg)
            S_RST_PLL: begin
                if (timer_reg == T_PLL_RST) state_next = S_WAIT_PLL;
            end
            S_WAIT_PLL: begin
                // Lock wins over a timeout that lands on the same cycle.
                if (pll_s) begin
                    state_next = S_RST_DCM;
                end else if (timer_reg == T_LOCK) begin
                    retries_next = retries_inc;
                    state_next   = (retries_inc == R_MAX) ? S_FAIL : S_RST_PLL;
                end
            end
            S_RST_DCM: begin
                if (!pll_s)                      state_next = S_RST_PLL;
                else if (timer_reg == T_DCM_RST) state_next = S_WAIT_DCM;
            end
            S_WAIT_DCM: begin
                if (!pll_s) begin
                    state_next = S_RST_PLL;
                end else if (dcm_s) begin
                    state_next = S_SETTLE;
                end else if (timer_reg == T_LOCK) begin
                    retries_next = retries_inc;
                    state_next   = (retries_inc == R_MAX) ? S_FAIL : S_RST_PLL;
                end
            end
            S_SETTLE: begin
                if (!pll_s) begin
                    state_next = S_RST_PLL;
                end else if (!dcm_s || stop_s) begin
                    state_next = S_RST_DCM;
                end else if (timer_reg == T_SETTLE) begin
                    state_next   = S_RUN;
                    retries_next = 3'd0;
                end
            end
            S_RUN: begin
                if (!pll_s)                  state_next = S_RST_PLL;
                else if (!dcm_s || stop_s)   state_next = S_RST_DCM;
            end
            S_FAIL: begin
                state_next = S_FAIL;
            end
            default: begin
                state_next = S_RST_PLL;
            end
        endcase

        // restart outranks everything except rst_n.
        if (restart) begin
            state_next   = S_RST_PLL;
            retries_next = 3'd0;
        end

        // The timer restarts on every state entry. A restart from RST_PLL
        // re-enters the same state, so it also clears the timer. In RUN and
        // FAIL the timer may wrap; nothing compares it there.
        if (restart || (state_next != state_reg)) timer_next = 20'd0;
        else                                      timer_next = timer_reg + 20'd1;

        // The outputs are decoded from the next state, so they are
        // registered on the same edge as the state.
        pll_rst_next   = (state_next == S_RST_PLL) || (state_next == S_FAIL);
        dcm_rst_next   = (state_next == S_RST_PLL) || (state_next == S_WAIT_PLL) ||
                         (state_next == S_RST_DCM) || (state_next == S_FAIL);
        sys_rst_next   = (state_next != S_RUN);
        clk_ready_next = (state_next == S_RUN);
        fail_next      = (state_next == S_FAIL);
    end

    always_ff @(posedge clk_33) begin
        if (!rst_n) begin
            state_reg   <= S_RST_PLL;
            timer_reg   <= 20'd0;
            retries_reg <= 3'd0;
            pll_rst     <= 1'b1;
            dcm_rst     <= 1'b1;
            sys_rst     <= 1'b1;
            clk_ready   <= 1'b0;
            fail        <= 1'b0;
        end else begin
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            retries_reg <= retries_next;
            pll_rst     <= pll_rst_next;
            dcm_rst     <= dcm_rst_next;
            sys_rst     <= sys_rst_next;
            clk_ready   <= clk_ready_next;
            fail        <= fail_next;
        end
    end

    assign retries = retries_reg;
    assign state   = state_reg;

endmodule

// File: tb/tb_clock_sequencer.sv
// tb_clock_sequencer
//
// Directed bench for clock_sequencer. There are two instances, and both
// are driven from the same inputs:
//   dut  - default parameters (used for nominal, DCM-loss, PLL-loss and
//          reset-in-SETTLE scenarios)
//   tdut - LOCK_TIMEOUT=64 (used for timeout, FAIL, restart and
//          retry-then-success scenarios)
// Inputs change 1 ns after a rising edge. Outputs are sampled at the same
// point. cyc counts rising edges since the last reset edge, so cyc=0 shows
// the reset values.
module tb_clock_sequencer;

    logic clk_33 = 1'b0;
    always #15 clk_33 = ~clk_33;

    logic rst_n, restart, pll_locked, dcm_locked, dcm_clkfx_stopped;

    logic       d_pll_rst, d_dcm_rst, d_sys_rst, d_clk_ready, d_fail;
    logic [2:0] d_retries, d_state;
    logic       t_pll_rst, t_dcm_rst, t_sys_rst, t_clk_ready, t_fail;
    logic [2:0] t_retries, t_state;

    clock_sequencer dut (
        .clk_33(clk_33), .rst_n(rst_n), .restart(restart),
        .pll_locked(pll_locked), .dcm_locked(dcm_locked),
        .dcm_clkfx_stopped(dcm_clkfx_stopped),
        .pll_rst(d_pll_rst), .dcm_rst(d_dcm_rst), .sys_rst(d_sys_rst),
        .clk_ready(d_clk_ready), .fail(d_fail), .retries(d_retries), .state(d_state)
    );

    clock_sequencer #(.LOCK_TIMEOUT(64)) tdut (
        .clk_33(clk_33), .rst_n(rst_n), .restart(restart),
        .pll_locked(pll_locked), .dcm_locked(dcm_locked),
        .dcm_clkfx_stopped(dcm_clkfx_stopped),
        .pll_rst(t_pll_rst), .dcm_rst(t_dcm_rst), .sys_rst(t_sys_rst),
        .clk_ready(t_clk_ready), .fail(t_fail), .retries(t_retries), .state(t_state)
    );

    int cyc      = 0;
    int n_checks = 0;
    int n_errors = 0;

    task automatic tick();
        @(posedge clk_33);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic do_reset();
        restart           = 1'b0;
        pll_locked        = 1'b0;
        dcm_locked        = 1'b0;
        dcm_clkfx_stopped = 1'b0;
        rst_n             = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".state"},     int'(d_state),     0);
        chk({tag, ".pll_rst"},   int'(d_pll_rst),   1);
        chk({tag, ".dcm_rst"},   int'(d_dcm_rst),   1);
        chk({tag, ".sys_rst"},   int'(d_sys_rst),   1);
        chk({tag, ".clk_ready"}, int'(d_clk_ready), 0);
        chk({tag, ".fail"},      int'(d_fail),      0);
        chk({tag, ".retries"},   int'(d_retries),   0);
    endtask

    initial begin
        logic held;

        // ---------------- nominal bring-up (dut) ----------------
        do_reset();
        $display("phase: reset values and nominal bring-up");
        chk_reset_vals("rst");
        run_to(3);   chk("nom.pll_rst_c3", int'(d_pll_rst), 1);
        run_to(4);   chk("nom.pll_rst_c4", int'(d_pll_rst), 0);
                     chk("nom.state_c4",   int'(d_state),   1);
        run_to(100); pll_locked = 1'b1;
        run_to(102); chk("nom.state_c102", int'(d_state), 1);
        run_to(103); chk("nom.state_c103", int'(d_state), 2);
                     chk("nom.dcm_rst_c103", int'(d_dcm_rst), 1);
        run_to(106); chk("nom.dcm_rst_c106", int'(d_dcm_rst), 1);
        run_to(107); chk("nom.dcm_rst_c107", int'(d_dcm_rst), 0);
                     chk("nom.state_c107", int'(d_state), 3);
        run_to(157); dcm_locked = 1'b1;
        run_to(160); chk("nom.state_c160", int'(d_state), 4);
        run_to(175); chk("nom.clk_ready_c175", int'(d_clk_ready), 0);
                     chk("nom.sys_rst_c175",   int'(d_sys_rst),   1);
        run_to(176); chk("nom.clk_ready_c176", int'(d_clk_ready), 1);
                     chk("nom.sys_rst_c176",   int'(d_sys_rst),   0);
                     chk("nom.retries_c176",   int'(d_retries),   0);
                     chk("nom.state_c176",     int'(d_state),     5);

        // ---------------- CLKFX stop pulse in RUN ----------------
        $display("phase: clkfx_stopped pulse in RUN");
        run_to(180); dcm_clkfx_stopped = 1'b1;
        run_to(182); chk("stop.clk_ready_c182", int'(d_clk_ready), 1);
        run_to(183); chk("stop.clk_ready_c183", int'(d_clk_ready), 0);
                     chk("stop.state_c183",     int'(d_state),     2);
                     chk("stop.pll_rst_c183",   int'(d_pll_rst),   0);
                     chk("stop.dcm_rst_c183",   int'(d_dcm_rst),   1);
        run_to(185); dcm_clkfx_stopped = 1'b0;
        run_to(186); chk("stop.dcm_rst_c186", int'(d_dcm_rst), 1);
        run_to(187); chk("stop.dcm_rst_c187", int'(d_dcm_rst), 0);
                     chk("stop.state_c187",   int'(d_state),   3);
        run_to(188); chk("stop.state_c188",   int'(d_state),   4);
        run_to(204); chk("stop.state_c204",   int'(d_state),   5);
                     chk("stop.clk_ready_c204", int'(d_clk_ready), 1);
                     chk("stop.pll_rst_c204",   int'(d_pll_rst),   0);

        // ---------------- simultaneous PLL + DCM loss in RUN ----------------
        $display("phase: PLL and DCM lock lost together in RUN");
        run_to(210); pll_locked = 1'b0; dcm_locked = 1'b0;
        run_to(212); chk("loss.state_c212",   int'(d_state),   5);
        run_to(213); chk("loss.state_c213",   int'(d_state),   0);
                     chk("loss.retries_c213", int'(d_retries), 0);
                     chk("loss.pll_rst_c213", int'(d_pll_rst), 1);
                     chk("loss.sys_rst_c213", int'(d_sys_rst), 1);
        pll_locked = 1'b1;
        run_to(215); dcm_locked = 1'b1;
        run_to(218); chk("loss.state_c218", int'(d_state), 2);
        run_to(223); chk("loss.state_c223", int'(d_state), 4);

        // ---------------- rst_n and restart together in SETTLE ----------------
        $display("phase: reset with restart during SETTLE");
        run_to(225); rst_n = 1'b0; restart = 1'b1;
        run_to(226); chk_reset_vals("midrst");
        rst_n = 1'b1; restart = 1'b0;
        run_to(229); chk("midrst.pll_rst_c229", int'(d_pll_rst), 1);
        run_to(230); chk("midrst.pll_rst_c230", int'(d_pll_rst), 0);
                     chk("midrst.state_c230",   int'(d_state),   1);
        run_to(231); chk("midrst.state_c231",   int'(d_state),   2);
        run_to(235); chk("midrst.state_c235",   int'(d_state),   3);
        run_to(236); chk("midrst.state_c236",   int'(d_state),   4);
        run_to(252); chk("midrst.state_c252",   int'(d_state),   5);
                     chk("midrst.clk_ready_c252", int'(d_clk_ready), 1);

        // ---------------- PLL never locks (tdut, timeout 64) ----------------
        do_reset();
        $display("phase: PLL never locks, three timeouts");
        chk("to.retries_c0", int'(t_retries), 0);
        run_to(67);  chk("to.state_c67",    int'(t_state),   1);
                     chk("to.retries_c67",  int'(t_retries), 0);
        run_to(68);  chk("to.state_c68",    int'(t_state),   0);
                     chk("to.retries_c68",  int'(t_retries), 1);
        run_to(136); chk("to.retries_c136", int'(t_retries), 2);
                     chk("to.state_c136",   int'(t_state),   0);
        run_to(203); chk("to.fail_c203",    int'(t_fail),    0);
        run_to(204); chk("to.fail_c204",    int'(t_fail),    1);
                     chk("to.state_c204",   int'(t_state),   6);
                     chk("to.pll_rst_c204", int'(t_pll_rst), 1);
                     chk("to.retries_c204", int'(t_retries), 3);
        held = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (!(t_fail && t_pll_rst && t_state == 3'd6)) held = 1'b0;
        end
        chk("to.fail_held_1000", int'(held), 1);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("rs.state",   int'(t_state),   0);
        chk("rs.retries", int'(t_retries), 0);
        chk("rs.fail",    int'(t_fail),    0);
        chk("rs.pll_rst", int'(t_pll_rst), 1);

        // ---------------- retry then success (tdut) ----------------
        // The restart edge is cyc 1205. The first attempt times out at 1273.
        $display("phase: retry then success");
        run_to(1273); chk("rt.retries_c1273", int'(t_retries), 1);
                      chk("rt.state_c1273",   int'(t_state),   0);
        run_to(1277); chk("rt.state_c1277",   int'(t_state),   1);
        run_to(1280); pll_locked = 1'b1; dcm_locked = 1'b1;
        run_to(1283); chk("rt.state_c1283",   int'(t_state),   2);
                      chk("rt.retries_c1283", int'(t_retries), 1);
        run_to(1288); chk("rt.state_c1288",   int'(t_state),   4);
        run_to(1303); chk("rt.clk_ready_c1303", int'(t_clk_ready), 0);
        run_to(1304); chk("rt.state_c1304",   int'(t_state),   5);
                      chk("rt.retries_c1304", int'(t_retries), 0);
                      chk("rt.sys_rst_c1304", int'(t_sys_rst), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
